// File: rtl/measure_pkg.sv
// Shared types for the cursor measurement engine: mode encodings, FSM states
// and the accumulator width derivation.
package measure_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_TIME = 2'd1,
    MODE_VOLT = 2'd2,
    MODE_FREQ = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIFF,
    S_MUL,
    S_DIV,
    S_SAT,
    S_DONE
  } state_t;

  // Wide enough for a cursor delta shifted up by the largest shrink value.
  function automatic int acc_width(input int cursor_w, input int shift_w);
    return cursor_w + (1 << shift_w) - 1;
  endfunction

endpackage

// File: rtl/measure_divider.sv
// Restoring serial divider: one quotient bit per cycle, DVD_W cycles per divide.
// The first step runs in the start cycle using the live inputs.
module measure_divider #(
  parameter int DVD_W = 24,
  parameter int DVS_W = 26
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic             div_by_zero
);
  localparam int CNT_W = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  logic [DVS_W-1:0] rem, rem_n, dvs_q, dvs;
  logic [DVD_W-1:0] quo, quo_n, src_quo;
  logic [DVS_W-1:0] src_rem;
  logic [DVS_W:0]   r2;
  logic [CNT_W-1:0] cnt;
  logic             run, dz;

  always_comb begin
    src_rem = run ? rem : '0;
    src_quo = run ? quo : dividend;
    dvs     = run ? dvs_q : divisor;
    r2      = {src_rem, src_quo[DVD_W-1]};
    rem_n   = r2[DVS_W-1:0];
    quo_n   = {src_quo[DVD_W-2:0], 1'b0};
    if (r2 >= {1'b0, dvs}) begin
      rem_n = DVS_W'(r2 - {1'b0, dvs});
      quo_n = {src_quo[DVD_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rem   <= '0;
      quo   <= '0;
      dvs_q <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      dz    <= 1'b0;
    end else if (!run && start) begin
      rem   <= rem_n;
      quo   <= quo_n;
      dvs_q <= divisor;
      cnt   <= CNT_W'(1);
      run   <= 1'b1;
      dz    <= (divisor == '0);
    end else if (run) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(DVD_W-1)) run <= 1'b0;
    end
  end

  assign busy        = run;
  assign done        = run && (cnt == CNT_W'(DVD_W-1));
  assign quotient    = quo;
  assign div_by_zero = dz;

endmodule

// File: rtl/measure_engine.sv
// Cursor measurement engine: captures cursors and per-channel settings on start,
// computes time / voltage / frequency through a serial mul/div and saturates.
module measure_engine
  import measure_pkg::*;
#(
  parameter int CURSOR_W = 11,
  parameter int NUM_CH   = 2,
  parameter int SR_W     = 6,
  parameter int SHIFT_W  = 4,
  parameter int OUT_W    = 14,
  parameter int SAT_MAX  = 9999,
  parameter int FREQ_K   = 1000000,
  parameter int K_W      = 24,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic [CURSOR_W-1:0]       cursorx1,
  input  logic [CURSOR_W-1:0]       cursorx2,
  input  logic [CURSOR_W-1:0]       cursory1,
  input  logic [CURSOR_W-1:0]       cursory2,
  input  logic [NUM_CH*SR_W-1:0]    sampleadjust,
  input  logic [NUM_CH*SHIFT_W-1:0] shiftdown,
  output logic                      busy,
  output logic                      done,
  output logic [OUT_W-1:0]          num,
  output logic                      overflow
);
  localparam int ACC_W = acc_width(CURSOR_W, SHIFT_W);
  localparam int MC_W  = $clog2(SR_W + 1);

  state_t state, nstate;
  mode_t  mode_q;

  logic [CURSOR_W-1:0] x1_q, x2_q, y1_q, y2_q, dx, dy;
  logic [SR_W-1:0]     sa_q;
  logic [SHIFT_W-1:0]  sh_q;
  logic [ACC_W-1:0]    acc, mcand, val;
  logic [SR_W:0]       mplier;
  logic [MC_W-1:0]     mcnt;
  logic                dz;
  logic [CH_W-1:0]     ch;

  logic             div_start, div_run, div_done, div_dz;
  logic [K_W-1:0]   div_q;

  // Out-of-range channel selects fall back to the last channel.
  assign ch  = (int'(ch_sel) >= NUM_CH) ? CH_W'(NUM_CH-1) : ch_sel;
  assign dx  = (x2_q >= x1_q) ? x2_q - x1_q : x1_q - x2_q;
  assign dy  = (y2_q >= y1_q) ? y2_q - y1_q : y1_q - y2_q;
  assign val = (mode_q == MODE_FREQ) ? ACC_W'(div_q) : acc;

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate    = state;
    div_start = 1'b0;
    case (state)
      S_IDLE: if (start) nstate = S_DIFF;
      S_DIFF: nstate = (mode_q == MODE_NONE || mode_q == MODE_VOLT) ? S_SAT : S_MUL;
      S_MUL:  if (mcnt == MC_W'(SR_W)) nstate = (mode_q == MODE_FREQ) ? S_DIV : S_SAT;
      S_DIV: begin
        // First DIV cycle decides: zero divisor skips straight to saturation.
        if (!div_run) begin
          if (acc == '0) nstate = S_SAT;
          else           div_start = 1'b1;
        end else if (div_done) begin
          nstate = S_SAT;
        end
      end
      S_SAT:  nstate = S_DONE;
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mode_q   <= MODE_NONE;
      x1_q     <= '0;
      x2_q     <= '0;
      y1_q     <= '0;
      y2_q     <= '0;
      sa_q     <= '0;
      sh_q     <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      mcnt     <= '0;
      dz       <= 1'b0;
      num      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q <= mode_t'(mode);
          x1_q   <= cursorx1;
          x2_q   <= cursorx2;
          y1_q   <= cursory1;
          y2_q   <= cursory2;
          sa_q   <= sampleadjust[ch*SR_W +: SR_W];
          sh_q   <= shiftdown[ch*SHIFT_W +: SHIFT_W];
        end
        S_DIFF: begin
          acc    <= (mode_q == MODE_VOLT) ? (ACC_W'(dy) << sh_q) : '0;
          mcand  <= ACC_W'(dx);
          mplier <= {1'b0, sa_q} + (SR_W+1)'(1);
          mcnt   <= '0;
          dz     <= 1'b0;
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          mcnt   <= mcnt + MC_W'(1);
        end
        S_DIV: if (!div_run && acc == '0) dz <= 1'b1;
        S_SAT: begin
          if (dz || (mode_q == MODE_FREQ && div_dz) || val > ACC_W'(SAT_MAX)) begin
            num      <= OUT_W'(SAT_MAX);
            overflow <= 1'b1;
          end else begin
            num      <= val[OUT_W-1:0];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  measure_divider #(
    .DVD_W (K_W),
    .DVS_W (ACC_W)
  ) u_div (
    .clock       (clock),
    .resetn      (resetn),
    .start       (div_start),
    .dividend    (K_W'(FREQ_K)),
    .divisor     (acc),
    .busy        (div_run),
    .done        (div_done),
    .quotient    (div_q),
    .div_by_zero (div_dz)
  );

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_measure_engine.sv
// Bench for measure_engine: vector table with a scoreboard queue, plus
// reset-abort, input-change, and held-start sequences.
module tb_measure_engine;
  localparam int CW = 11;
  localparam int SRW = 6;
  localparam int SHW = 4;

  logic           clock, resetn, start;
  logic [1:0]     mode;
  logic           ch_sel;
  logic [CW-1:0]  cursorx1, cursorx2, cursory1, cursory2;
  logic [2*SRW-1:0] sampleadjust;
  logic [2*SHW-1:0] shiftdown;
  logic           busy, done, overflow;
  logic [13:0]    num;

  measure_engine dut (
    .clock(clock), .resetn(resetn), .start(start), .mode(mode), .ch_sel(ch_sel),
    .cursorx1(cursorx1), .cursorx2(cursorx2), .cursory1(cursory1), .cursory2(cursory2),
    .sampleadjust(sampleadjust), .shiftdown(shiftdown),
    .busy(busy), .done(done), .num(num), .overflow(overflow)
  );

  typedef struct {
    int mode, ch, x1, x2, y1, y2, sa0, sa1, sh0, sh1, num, ovf, lat;
  } vec_t;
  typedef struct { int num, ovf, lat, acc; } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   pass_cnt = 0, total_cnt = 0;
  int   cyc = 0, unexp = 0, wide = 0;
  bit   mon_en = 1, done_prev = 0;

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (done && done_prev) wide++;
    if (mon_en && done) begin
      if (sb.size() == 0) unexp++;
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("num", int'(num), e.num);
        chk("overflow", int'(overflow), e.ovf);
        chk("latency", cyc - e.acc + 2, e.lat);
      end
    end
    done_prev = done;
  end

  task automatic set_inputs(input vec_t v);
    mode         = 2'(v.mode);
    ch_sel       = 1'(v.ch);
    cursorx1     = CW'(v.x1);
    cursorx2     = CW'(v.x2);
    cursory1     = CW'(v.y1);
    cursory2     = CW'(v.y2);
    sampleadjust = {SRW'(v.sa1), SRW'(v.sa0)};
    shiftdown    = {SHW'(v.sh1), SHW'(v.sh0)};
  endtask

  task automatic drive(input vec_t v, input bit push);
    set_inputs(v);
    start = 1;
    @(posedge clock); #1;
    start = 0;
    if (push) sb.push_back('{v.num, v.ovf, v.lat, cyc});
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    //          mode ch  x1    x2    y1    y2  sa0 sa1 sh0 sh1  num   ovf lat
    vecs[0]  = '{1, 1, 100,   40,   0,    0,   9,  4,  0,  0,  300,  0, 11};
    vecs[1]  = '{2, 0, 0,     0,    10,   200, 0,  0,  3,  7,  1520, 0, 4};
    vecs[2]  = '{2, 1, 0,     0,    10,   200, 0,  0,  3,  7,  9999, 1, 4};
    vecs[3]  = '{3, 0, 0,     200,  0,    0,   4,  0,  0,  0,  1000, 0, 35};
    vecs[4]  = '{3, 0, 555,   555,  0,    0,   4,  0,  0,  0,  9999, 1, 12};
    vecs[5]  = '{0, 0, 5,     900,  3,    700, 4,  4,  2,  2,  0,    0, 4};
    vecs[6]  = '{1, 0, 1111,  0,    0,    0,   8,  0,  0,  0,  9999, 0, 11};
    vecs[7]  = '{1, 0, 0,     1250, 0,    0,   7,  0,  0,  0,  9999, 1, 11};
    vecs[8]  = '{1, 0, 2047,  47,   0,    0,   63, 0,  0,  0,  9999, 1, 11};
    vecs[9]  = '{3, 0, 60,    0,    0,    0,   4,  0,  0,  0,  3333, 0, 35};
    vecs[10] = '{3, 0, 0,     1000, 0,    0,   9,  0,  0,  0,  100,  0, 35};
    vecs[11] = '{3, 0, 1,     0,    0,    0,   0,  0,  0,  0,  9999, 1, 35};
    vecs[12] = '{2, 0, 0,     0,    77,   77,  0,  0,  15, 0,  0,    0, 4};
    vecs[13] = '{2, 0, 0,     0,    2047, 0,   0,  0,  0,  0,  2047, 0, 4};

    resetn = 0; start = 0;
    set_inputs(vecs[0]);
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_num", int'(num), 0);
    chk("rst_ovf", int'(overflow), 0);
    resetn = 1;
    @(posedge clock); #1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i], 1);
      wait_empty(100);
    end

    // Reset in the middle of MUL: no done, outputs cleared.
    drive(vecs[0], 0);
    repeat (4) @(posedge clock);
    #1 resetn = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_num", int'(num), 0);
    chk("abort_ovf", int'(overflow), 0);
    resetn = 1;
    repeat (30) @(posedge clock);
    #1;

    // Inputs changed and start re-asserted while busy: result unaffected.
    drive(vecs[0], 1);
    cursorx2 = CW'(500);
    sampleadjust = '1;
    mode = 2'd3;
    start = 1;
    repeat (3) @(posedge clock);
    #1 start = 0;
    wait_empty(100);

    // Start held high: back-to-back runs separated by one IDLE cycle.
    begin
      int dn = 0, last = -1, badgap = 0;
      mon_en = 0;
      set_inputs(vecs[1]);
      start = 1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        if (done) begin
          if (last >= 0 && i - last != 4) badgap++;
          last = i;
          dn++;
        end
      end
      start = 0;
      chk("hold_pulses", dn, 5);
      chk("hold_gap", badgap, 0);
      chk("hold_num", int'(num), 1520);
      @(posedge clock); #1;
      chk("hold_idle_busy", int'(busy), 0);
      mon_en = 1;
    end

    repeat (10) @(posedge clock);
    #1;
    chk("unexpected_done", unexp, 0);
    chk("done_width", wide, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
